// File: rtl/log_mult_dot_accum_if.sv
// ============================================================================
// Module      : log_mult_dot_accum_if
// Description : Product-in / dot-product-out handshake bundle
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface log_mult_dot_accum_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 4
) ();
    logic              i_prod_valid;
    logic              o_prod_ready;
    logic [PROD_W-1:0] i_prod;
    logic              i_prod_last;
    logic              o_acc_valid;
    logic              i_acc_ready;
    logic [ACC_W-1:0]  o_acc;
    logic [CNT_W-1:0]  o_acc_count;
    logic              o_acc_sat;

    modport slave (
        input  i_prod_valid, i_prod, i_prod_last, i_acc_ready,
        output o_prod_ready, o_acc_valid, o_acc, o_acc_count, o_acc_sat
    );

    modport master (
        output i_prod_valid, i_prod, i_prod_last, i_acc_ready,
        input  o_prod_ready, o_acc_valid, o_acc, o_acc_count, o_acc_sat
    );
endinterface

`default_nettype wire

// File: rtl/log_mult_dot_accum.sv
// ============================================================================
// Module      : log_mult_dot_accum
// Description : Saturating group accumulator for signed approximate products
// Revision    : 1.0
// ============================================================================
`default_nettype none

module log_mult_dot_accum #(
    parameter  int PROD_W = 32,
    parameter  int ACC_W  = 40,
    parameter  int LEN    = 8,
    localparam int CNT_W  = $clog2(LEN + 1)
) (
    input  wire logic               i_clk,
    input  wire logic               i_rst,
    log_mult_dot_accum_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] c_SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_sum;
    logic [CNT_W-1:0]   r_count;
    logic               r_sat;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_acc_count;
    logic               r_acc_sat;

    logic               w_ready;
    logic               w_accept;
    logic               w_close;
    logic [ACC_W:0]     w_sum_ext;
    logic [ACC_W-1:0]   w_sum_clamp;
    logic               w_sat_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    assign w_ready  = (r_state == ST_ACCUM) || bus.i_acc_ready;
    assign w_accept = bus.i_prod_valid && w_ready;

    // Running sum is already zero while holding, so a product accepted in
    // HOLD naturally starts the next group.
    assign w_sum_ext = {r_sum[ACC_W-1], r_sum}
                     + {{(ACC_W+1-PROD_W){bus.i_prod[PROD_W-1]}}, bus.i_prod};
    assign w_cnt_nxt = r_count + CNT_W'(1);
    assign w_close   = w_accept && ((w_cnt_nxt == CNT_W'(LEN)) || bus.i_prod_last);

    // Overflow shows as disagreement between the guard bit and the sign bit.
    always_comb begin
        w_sum_clamp = w_sum_ext[ACC_W-1:0];
        w_sat_nxt   = r_sat;
        if (w_sum_ext[ACC_W] != w_sum_ext[ACC_W-1]) begin
            w_sum_clamp = w_sum_ext[ACC_W] ? c_SAT_MIN : c_SAT_MAX;
            w_sat_nxt   = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: if (w_close) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (bus.i_acc_ready) w_state_nxt = w_close ? ST_HOLD : ST_ACCUM;
            default:  w_state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_ACCUM;
            r_sum       <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_acc       <= '0;
            r_acc_count <= '0;
            r_acc_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (w_close) begin
                    r_acc       <= w_sum_clamp;
                    r_acc_count <= w_cnt_nxt;
                    r_acc_sat   <= w_sat_nxt;
                    r_sum       <= '0;
                    r_count     <= '0;
                    r_sat       <= 1'b0;
                end else begin
                    r_sum       <= w_sum_clamp;
                    r_count     <= w_cnt_nxt;
                    r_sat       <= w_sat_nxt;
                end
            end
        end
    end

    assign bus.o_prod_ready = w_ready;
    assign bus.o_acc_valid  = (r_state == ST_HOLD);
    assign bus.o_acc        = r_acc;
    assign bus.o_acc_count  = r_acc_count;
    assign bus.o_acc_sat    = r_acc_sat;

endmodule

`default_nettype wire

// File: tb/tb_log_mult_dot_accum.sv
// ============================================================================
// Module      : tb_log_mult_dot_accum
// Description : Self-checking bench; ACC_W=40 and ACC_W=34 instances share stimulus
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_log_mult_dot_accum;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    log_mult_dot_accum_if #(.PROD_W(32), .ACC_W(40), .CNT_W(4)) if0 ();
    log_mult_dot_accum_if #(.PROD_W(32), .ACC_W(34), .CNT_W(4)) if1 ();

    log_mult_dot_accum #(.PROD_W(32), .ACC_W(40), .LEN(8)) u_dut0 (
        .i_clk (clk), .i_rst (rst), .bus (if0.slave));
    log_mult_dot_accum #(.PROD_W(32), .ACC_W(34), .LEN(8)) u_dut1 (
        .i_clk (clk), .i_rst (rst), .bus (if1.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: integer group sum with clamping after every add
    longint m_sum[2], m_acc[2], m_max[2], m_min[2];
    int     m_cnt[2], m_acccnt[2];
    bit     m_sat[2], m_accsat[2], m_valid[2];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint get_acc(input int d);
        return (d == 0) ? longint'($signed(if0.o_acc)) : longint'($signed(if1.o_acc));
    endfunction

    task automatic check_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d valid", tag, d),
                (d == 0) ? if0.o_acc_valid : if1.o_acc_valid, m_valid[d]);
            chk($sformatf("%s d%0d acc", tag, d), get_acc(d), m_acc[d]);
            chk($sformatf("%s d%0d count", tag, d),
                (d == 0) ? if0.o_acc_count : if1.o_acc_count, m_acccnt[d]);
            chk($sformatf("%s d%0d sat", tag, d),
                (d == 0) ? if0.o_acc_sat : if1.o_acc_sat, m_accsat[d]);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_sum[d] = 0; m_cnt[d] = 0; m_sat[d] = 0;
            m_acc[d] = 0; m_acccnt[d] = 0; m_accsat[d] = 0; m_valid[d] = 0;
        end
    endtask

    // One clock: drive, check ready, advance model, check registered outputs.
    task automatic step(input bit v, input longint p, input bit l, input bit r, input bit rs);
        bit     exp_rdy, consumed, closed;
        longint s;
        bit     sat;
        int     c;
        rst = rs;
        if0.i_prod_valid = v; if0.i_prod = p[31:0]; if0.i_prod_last = l; if0.i_acc_ready = r;
        if1.i_prod_valid = v; if1.i_prod = p[31:0]; if1.i_prod_last = l; if1.i_acc_ready = r;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_rdy = !m_valid[d] || r;
            chk($sformatf("ready d%0d", d),
                (d == 0) ? if0.o_prod_ready : if1.o_prod_ready, exp_rdy);
            if (rs) continue;
            consumed = m_valid[d] && r;
            closed   = 0;
            if (v && exp_rdy) begin
                s   = m_sum[d] + p;
                sat = m_sat[d];
                if (s > m_max[d]) begin s = m_max[d]; sat = 1; end
                else if (s < m_min[d]) begin s = m_min[d]; sat = 1; end
                c = m_cnt[d] + 1;
                if (c == 8 || l) begin
                    m_acc[d] = s; m_acccnt[d] = c; m_accsat[d] = sat; m_valid[d] = 1;
                    m_sum[d] = 0; m_cnt[d] = 0; m_sat[d] = 0;
                    closed = 1;
                end else begin
                    m_sum[d] = s; m_cnt[d] = c; m_sat[d] = sat;
                end
            end
            if (consumed && !closed) m_valid[d] = 0;
        end
        if (rs) model_reset();
        @(posedge clk);
        #1;
        check_outputs("step");
    endtask

    typedef struct {
        int     n;
        longint p[8];
        bit     last;
        longint e0;
        longint e1;
        int     ecnt;
        bit     s0;
        bit     s1;
    } grp_t;

    localparam longint P_MAX = 64'sd2147483647;
    localparam longint P_MIN = -64'sd2147483648;

    grp_t tbl[7];
    longint held;

    initial begin
        tbl[0] = '{8, '{1,2,3,4,5,6,7,8}, 0, 36, 36, 8, 0, 0};
        tbl[1] = '{8, '{-5,3,-7,2,0,0,0,0}, 0, -7, -7, 8, 0, 0};
        tbl[2] = '{3, '{10,20,30,0,0,0,0,0}, 1, 60, 60, 3, 0, 0};
        tbl[3] = '{8, '{1,1,1,1,1,1,1,1}, 0, 8, 8, 8, 0, 0};
        tbl[4] = '{8, '{P_MAX,P_MAX,P_MAX,P_MAX,P_MAX,P_MAX,P_MAX,P_MAX}, 0,
                   64'sd17179869176, 64'sd8589934591, 8, 0, 1};
        tbl[5] = '{8, '{P_MIN,P_MIN,P_MIN,P_MIN,P_MIN,P_MIN,P_MIN,P_MIN}, 0,
                   -64'sd17179869184, -64'sd8589934592, 8, 0, 1};
        tbl[6] = '{1, '{5,0,0,0,0,0,0,0}, 1, 5, 5, 1, 0, 0};

        m_max[0] = (64'sd1 <<< 39) - 1; m_min[0] = -(64'sd1 <<< 39);
        m_max[1] = (64'sd1 <<< 33) - 1; m_min[1] = -(64'sd1 <<< 33);
        model_reset();

        rst = 1'b1;
        if0.i_prod_valid = 0; if0.i_prod = '0; if0.i_prod_last = 0; if0.i_acc_ready = 1;
        if1.i_prod_valid = 0; if1.i_prod = '0; if1.i_prod_last = 0; if1.i_acc_ready = 1;
        @(posedge clk); #1;
        check_outputs("reset");
        step(0, 0, 0, 1, 0);

        // Table of groups, back-to-back with the consumer always ready
        foreach (tbl[g]) begin
            for (int i = 0; i < tbl[g].n; i++)
                step(1, tbl[g].p[i], tbl[g].last && (i == tbl[g].n - 1), 1, 0);
            chk($sformatf("tbl%0d valid", g), if0.o_acc_valid, 1);
            chk($sformatf("tbl%0d acc d0", g), get_acc(0), tbl[g].e0);
            chk($sformatf("tbl%0d acc d1", g), get_acc(1), tbl[g].e1);
            chk($sformatf("tbl%0d count", g), if1.o_acc_count, tbl[g].ecnt);
            chk($sformatf("tbl%0d sat d0", g), if0.o_acc_sat, tbl[g].s0);
            chk($sformatf("tbl%0d sat d1", g), if1.o_acc_sat, tbl[g].s1);
        end
        step(0, 0, 0, 1, 0);
        chk("single-cycle valid", if0.o_acc_valid, 0);

        // Backpressure: result held, 99 stalls, then enters the next group
        step(1, 1, 0, 1, 0);
        step(1, 2, 0, 1, 0);
        step(1, 3, 1, 1, 0);
        held = get_acc(0);
        chk("bp closed sum", held, 6);
        for (int i = 0; i < 5; i++) begin
            step(1, 99, 0, 0, 0);
            chk("bp ready low", if0.o_prod_ready, 0);
            chk("bp stable", get_acc(0), 6);
            chk("bp valid held", if0.o_acc_valid, 1);
        end
        step(1, 99, 0, 1, 0);
        chk("bp valid drops", if0.o_acc_valid, 0);
        step(1, 1, 1, 1, 0);
        chk("bp next sum", get_acc(0), 100);
        chk("bp next count", if0.o_acc_count, 2);

        // Reset mid-group discards the partial sum
        for (int i = 0; i < 4; i++) step(1, 100, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        chk("rst valid", if0.o_acc_valid, 0);
        chk("rst acc", get_acc(0), 0);
        step(0, 0, 0, 1, 0);
        chk("post-rst valid", if0.o_acc_valid, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 0);
        chk("post-rst sum", get_acc(0), 8);
        chk("post-rst count", if0.o_acc_count, 8);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            longint p;
            case ($urandom_range(3))
                0: p = longint'($urandom_range(200)) - 100;
                1: p = P_MAX;
                2: p = P_MIN;
                default: p = longint'($signed($urandom()));
            endcase
            step($urandom_range(3) != 0, p, $urandom_range(7) == 0,
                 $urandom_range(3) != 0, $urandom_range(99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/log_mult_dot_accum.md
Name: log_mult_dot_accum

Overview:
Downstream consumer of the 16x16 signed Mitchell log multiplier. Accepts a stream of signed 32-bit approximate products over a valid/ready handshake. Accumulates each group of LEN products, or a shorter group closed by i_prod_last, into a wider saturating accumulator. Presents the dot-product result on a registered valid/ready output port, with zero-bubble turnover between groups.

Parameters:
PROD_W, 32, width of the signed product input (matches the multiplier output o_z)
ACC_W, 40, accumulator/result width, signed; must be >= PROD_W+1
LEN, 8, products per group; legal range 1..255
CNT_W, $clog2(LEN+1), width of the product-count output (derived; do not override)

Ports:
i_clk  input  1  clock, all state updates on the rising edge
i_rst  input  1  synchronous active-high reset
i_prod_valid  input  1  product beat valid
o_prod_ready  output  1  block can accept a product this cycle
i_prod  input  PROD_W  signed product
i_prod_last  input  1  this beat closes the group early; qualified by the handshake
o_acc_valid  output  1  result valid
i_acc_ready  input  1  downstream accepts the result
o_acc  output  ACC_W  signed group sum
o_acc_count  output  CNT_W  number of products in the group
o_acc_sat  output  1  saturation occurred at least once in the group

Behaviour:
- Reset is synchronous and active-high; one clock.
- On i_rst:
  - state = ACCUM; running sum = 0; running count = 0; sticky sat = 0.
  - o_acc_valid = 0; o_acc = 0; o_acc_count = 0; o_acc_sat = 0.
  - Reset mid-group discards the partial sum and any held result.
- States:
  - ACCUM: collecting products.
  - HOLD: result presented, waiting for downstream.
- o_prod_ready (combinational) = (state==ACCUM) || (state==HOLD && i_acc_ready).
- A product is accepted when i_prod_valid && o_prod_ready.
- Add step, on each accepted product:
  - Sign-extend i_prod to ACC_W+1 bits and add to the sign-extended running sum.
  - If the result exceeds 2^(ACC_W-1)-1, clamp to that value. If it is below -2^(ACC_W-1), clamp to that value.
  - Set sticky sat on either clamp.
  - Clamping happens at every step, not only at the end of the group.
- Group close occurs on the accepted beat where the new count == LEN, or where i_prod_last=1. Both in the same beat is a single close.
  - Next edge: o_acc <= clamped sum; o_acc_count <= new count; o_acc_sat <= new sticky sat; o_acc_valid <= 1; state <= HOLD.
  - Running sum, count and sat clear to 0 on the same edge.
  - Latency: result is valid 1 cycle after the closing product is accepted.
- HOLD:
  - o_acc, o_acc_count and o_acc_sat hold stable while o_acc_valid && !i_acc_ready.
  - No products are accepted while i_acc_ready=0.
- HOLD with i_acc_ready=1:
  - The result is consumed.
  - If a product is accepted the same cycle, it becomes the first element of the new group (sum = that product, count = 1) and state goes to ACCUM.
  - If that product also closes the group (LEN=1, or i_prod_last=1), state stays HOLD and o_acc_valid stays 1 with the new result.
  - If no product is accepted, o_acc_valid <= 0 and state goes to ACCUM.
- Throughput: one product per cycle sustained when i_acc_ready=1; no bubble between groups.
- i_prod_last on a beat that is not accepted has no effect.
- Data outputs are don't-care-free: when o_acc_valid=0 they keep their last values (0 after reset).

Test Plan:
1. LEN=8, i_acc_ready=1, products 1..8 back-to-back -> o_acc=36, o_acc_count=8, o_acc_sat=0; o_acc_valid high for exactly 1 cycle, 1 cycle after the 8th accept; o_prod_ready stays 1 throughout.
2. Signed mix {-5,3,-7,2,0,0,0,0} -> o_acc=-7 (all ones above bit 2), count=8, sat=0.
3. Early close: products 10,20,30 with i_prod_last on the 3rd -> o_acc=60, o_acc_count=3. Next group of 8 ones -> o_acc=8 (no carry-over).
4. Backpressure: hold i_acc_ready=0 for 5 cycles after a close.
   - o_acc_valid=1 and outputs stable; o_prod_ready=0; i_prod_valid held with value 99 is not consumed.
   - Raise i_acc_ready: 99 is accepted that cycle, o_acc_valid drops next cycle, and the next group sum starts at 99.
5. Saturation, ACC_W=34, LEN=8:
   - 8x(2^31-1) -> o_acc=2^33-1, sat=1.
   - 8x(-2^31) -> o_acc=-2^33, sat=1.
   - Following group {5} with last -> o_acc=5, sat=0.
6. Reset mid-group: accept 4 products of 100, assert i_rst for 1 cycle, then send 8 ones -> o_acc=8, count=8; o_acc_valid=0 during and immediately after reset.
